// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking accumulator: FSM states,
// saturating add, and address-width derivation.
package snn_pkg;

  typedef enum logic [1:0] {ACCUM, FIRE, EMIT} acc_state_e;

  localparam int DEF_PSUM_WIDTH     = 12;
  localparam int DEF_MEMBRANE_WIDTH = 14;
  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_NUM_PIXELS     = 16;
  localparam int DEF_NUM_TIMESTEPS  = 2;

  // Counter width that stays >= 1 bit even when only one value exists
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Unsigned add clamped to 2^w-1; operands must already fit in w bits
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/vmem_regfile.sv
// Membrane potential store: one flop row per output pixel, async clear,
// combinational read, single synchronous write.
module vmem_regfile
  import snn_pkg::*;
#(
  parameter int W  = DEF_MEMBRANE_WIDTH,
  parameter int N  = DEF_NUM_PIXELS,
  parameter int AW = $clog2(DEF_NUM_PIXELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [N-1:0][W-1:0] mem;

  for (genvar g = 0; g < N; g++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          mem[g] <= '0;
      else if (we && waddr == AW'(g))     mem[g] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spike_accumulator.sv
// Accumulates NUM_CH partial sums per pixel into its membrane potential,
// fires against a threshold and keeps the residual across timesteps.
module spike_accumulator
  import snn_pkg::*;
#(
  parameter int PSUM_WIDTH     = DEF_PSUM_WIDTH,
  parameter int MEMBRANE_WIDTH = DEF_MEMBRANE_WIDTH,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int NUM_PIXELS     = DEF_NUM_PIXELS,
  parameter int NUM_TIMESTEPS  = DEF_NUM_TIMESTEPS,
  localparam int PIX_AW        = $clog2(NUM_PIXELS),
  localparam int TS_AW         = clog2_min1(NUM_TIMESTEPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEMBRANE_WIDTH-1:0] cfg_threshold,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [PSUM_WIDTH-1:0]     psum_data,
  output logic                      spike_valid,
  input  logic                      spike_ready,
  output logic                      spike_data,
  output logic [PIX_AW-1:0]         spike_addr,
  output logic [TS_AW-1:0]          spike_ts,
  output logic                      frame_done
);

  localparam int CH_W = clog2_min1(NUM_CH + 1);
  localparam int MW   = MEMBRANE_WIDTH;

  acc_state_e          state;
  logic [MW-1:0]       acc;
  logic [CH_W-1:0]     ch_cnt;
  logic [PIX_AW-1:0]   pix_cnt;
  logic [TS_AW-1:0]    ts_cnt;

  logic [MW-1:0]       vmem_rd;
  logic [MW-1:0]       vmem_wd;
  logic [MW-1:0]       sum;
  logic [MW-1:0]       acc_nxt;
  logic                fire;
  logic                last_ts;
  logic                vmem_we;

  always_comb begin
    acc_nxt = MW'(sat_add(32'(acc), 32'(psum_data), MW));
    sum     = MW'(sat_add(32'(acc), 32'(vmem_rd), MW));
    fire    = (sum >= cfg_threshold);
    last_ts = (ts_cnt == TS_AW'(NUM_TIMESTEPS - 1));
    // Last timestep of a frame drops the residual so the next frame starts clean
    vmem_wd = last_ts ? '0 : (fire ? sum - cfg_threshold : sum);
    vmem_we = (state == FIRE);
  end

  vmem_regfile #(.W(MW), .N(NUM_PIXELS), .AW(PIX_AW)) u_vmem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (vmem_we),
    .waddr (pix_cnt),
    .wdata (vmem_wd),
    .raddr (pix_cnt),
    .rdata (vmem_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      ch_cnt      <= '0;
      pix_cnt     <= '0;
      ts_cnt      <= '0;
      psum_ready  <= 1'b0;
      spike_valid <= 1'b0;
      spike_data  <= 1'b0;
      spike_addr  <= '0;
      spike_ts    <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ACCUM: begin
          psum_ready <= 1'b1;
          if (psum_valid && psum_ready) begin
            acc    <= acc_nxt;
            ch_cnt <= ch_cnt + 1'b1;
            if (ch_cnt == CH_W'(NUM_CH - 1)) begin
              psum_ready <= 1'b0;
              state      <= FIRE;
            end
          end
        end
        FIRE: begin
          spike_data  <= fire;
          spike_addr  <= pix_cnt;
          spike_ts    <= ts_cnt;
          spike_valid <= 1'b1;
          state       <= EMIT;
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            psum_ready  <= 1'b1;
            acc         <= '0;
            ch_cnt      <= '0;
            state       <= ACCUM;
            if (pix_cnt == PIX_AW'(NUM_PIXELS - 1)) begin
              pix_cnt <= '0;
              if (last_ts) begin
                ts_cnt     <= '0;
                frame_done <= 1'b1;
              end else begin
                ts_cnt <= ts_cnt + 1'b1;
              end
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_accumulator.sv
// Directed bench: threshold/residual, backpressure, saturation, mid-op reset
// and frame sequencing on a 4-pixel, 2-timestep, 3-channel instance.
module tb_spike_accumulator;

  localparam int PW = 12, MW = 13, NCH = 3, NPIX = 4, NTS = 2;
  localparam int PIX_AW = 2, TS_AW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [MW-1:0]     cfg_threshold;
  logic              psum_valid;
  logic              psum_ready;
  logic [PW-1:0]     psum_data;
  logic              spike_valid;
  logic              spike_ready;
  logic              spike_data;
  logic [PIX_AW-1:0] spike_addr;
  logic [TS_AW-1:0]  spike_ts;
  logic              frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  spike_accumulator #(
    .PSUM_WIDTH(PW), .MEMBRANE_WIDTH(MW), .NUM_CH(NCH),
    .NUM_PIXELS(NPIX), .NUM_TIMESTEPS(NTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_threshold(cfg_threshold),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_data(spike_data),
    .spike_addr(spike_addr), .spike_ts(spike_ts), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge
  task automatic send(input int d);
    int n = 0;
    psum_valid = 1'b1;
    psum_data  = PW'(d);
    while (!psum_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("psum_timeout", 0, 1);
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic pixel(input int a, input int b, input int c);
    send(a); send(b); send(c);
  endtask

  task automatic get_spike(input string tag, input int d, input int addr, input int ts);
    int n = 0;
    while (!spike_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_data"}, 32'(spike_data), d);
    chk({tag, "_addr"}, 32'(spike_addr), addr);
    chk({tag, "_ts"},   32'(spike_ts), ts);
    spike_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag, input int thr);
    rst_n         = 1'b0;
    psum_valid    = 1'b0;
    cfg_threshold = MW'(thr);
    repeat (2) @(negedge clk);
    chk({tag, "_outs"},
        {25'd0, psum_ready, spike_valid, spike_data, spike_addr, spike_ts, frame_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; psum_valid = 1'b0; psum_data = '0;
    spike_ready = 1'b1; cfg_threshold = MW'(100);
    @(negedge clk);
    do_reset("rst0", 100);

    // ts0: pix0 fires (120 >= 100, residual 20); check 2-edge latency
    send(30); send(40); send(50);
    chk("fire_cycle_valid", 32'(spike_valid), 0);
    chk("fire_cycle_ready", 32'(psum_ready), 0);
    @(negedge clk);
    chk("latency_valid", 32'(spike_valid), 1);
    get_spike("t1", 1, 0, 0);

    // pix1 held under backpressure for 10 cycles
    spike_ready = 1'b0;
    pixel(0, 0, 0);
    begin
      int n = 0;
      while (!spike_valid && n < 50) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {27'd0, spike_valid, psum_ready, spike_data, spike_addr}, 5'b10001);
      chk("bp_ts", 32'(spike_ts), 0);
      @(negedge clk);
    end
    get_spike("t3", 0, 1, 0);
    pixel(0, 0, 0); get_spike("ts0p2", 0, 2, 0);
    pixel(0, 0, 0); get_spike("ts0p3", 0, 3, 0);

    // ts1: pix0 residual 20 + 30 = 50, no fire; residual then dropped
    base = fd_cnt;
    pixel(10, 10, 10); get_spike("t2", 0, 0, 1);
    for (int p = 1; p < 4; p++) begin
      pixel(0, 0, 0); get_spike("ts1", 0, p, 1);
    end
    chk("frame_done_pulse", 32'(frame_done), 1);
    @(negedge clk);
    chk("frame_done_once", 32'(fd_cnt - base), 1);

    // next frame: pix0 starts from 0 (90 < 100), pix1 fires leaving 20
    pixel(30, 30, 30); get_spike("f2p0", 0, 0, 0);
    pixel(30, 40, 50); get_spike("f2p1", 1, 1, 0);

    // reset after 2 of 3 psums: partial acc and residuals must vanish
    send(30); send(30);
    do_reset("t5", 100);
    pixel(30, 30, 30); get_spike("t5p0", 0, 0, 0);
    pixel(40, 40, 0);  get_spike("t5p1", 0, 1, 0);

    // saturation: 3x4095 clamps to 8191, fires at 8000, residual 191
    do_reset("rst4", 8000);
    pixel(4095, 4095, 4095); get_spike("t4sat", 1, 0, 0);
    pixel(4095, 3905, 0);    get_spike("t4eq", 1, 1, 0);
    pixel(4095, 3904, 0);    get_spike("t4lt", 0, 2, 0);
    pixel(0, 0, 0);          get_spike("t4p3", 0, 3, 0);
    pixel(4095, 3713, 0);    get_spike("t4res", 0, 0, 1);
    pixel(0, 0, 0);          get_spike("t4p1z", 0, 1, 1);
    pixel(1, 0, 0);          get_spike("t4carry", 1, 2, 1);
    pixel(0, 0, 0);          get_spike("t4p3b", 0, 3, 1);

    // threshold 0: everything fires, full frame sequencing
    do_reset("rst6", 0);
    base = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      pixel(0, 0, 0);
      get_spike("t6", 1, i % 4, i / 4);
      if (i < 7) chk("t6_no_fd", 32'(frame_done), 0);
    end
    repeat (3) @(negedge clk);
    chk("t6_frame_done", 32'(fd_cnt - base), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
